inert_integrator_mc: RTL and testbench

- Parametrised, multi-channel successor to the single-purpose inertial integrator used by inert_intf.
- Takes NUM_CH signed gyro-rate channels per sample strobe and calibrates a per-channel rate offset by averaging 2^CAL_LOG2 samples.
- After calibration, integrates offset-compensated rate into a fixed-point angle with optional per-channel accelerometer leak fusion and saturation.
- Sits between the SPI/IMU front end (supplies vld, rates, accel angles) and the flight controller (consumes angles, ang_vld, cal_done).

---
 rtl/inert_pkg.sv | 27 ++
 rtl/inert_axis.sv | 84 ++++++++
 rtl/inert_integrator_mc.sv | 92 +++++++++
 tb/tb_inert_integrator_mc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/inert_pkg.sv
// Shared types and helpers for the multi-channel inertial integrator.
package inert_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  function automatic int acc_w(input int w, input int cal_log2);
    return w + cal_log2;
  endfunction

  function automatic int int_w(input int w, input int frac);
    return w + frac;
  endfunction

  // Returns {above max, below min} for x against a w-bit signed range.
  function automatic logic [1:0] sat_flags(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return {x > hi, x < lo};
  endfunction

endpackage

// File: rtl/inert_axis.sv
// Per-axis datapath: calibration accumulator, rate offset, fusion and
// saturating fixed-point integrator.
module inert_axis
  import inert_pkg::*;
#(
  parameter int W         = 16,
  parameter int FRAC      = 11,
  parameter int CAL_LOG2  = 11,
  parameter bit FUSE_EN   = 1'b1,
  parameter int FUSE_STEP = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         cal_en,
  input  logic         cal_last,
  input  logic         run_en,
  input  logic [W-1:0] rate,
  input  logic [W-1:0] accel_ang,
  output logic [W-1:0] angle
);

  localparam int ACC_W = acc_w(W, CAL_LOG2);
  localparam int INT_W = int_w(W, FRAC);
  localparam int NXT_W = INT_W + 2;
  localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  logic signed [W-1:0]     rate_s;
  logic signed [W-1:0]     accel_s;
  logic signed [W-1:0]     offset;
  logic signed [W-1:0]     angle_s;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [W:0]       rc;
  logic signed [NXT_W-1:0] fuse;
  logic signed [NXT_W-1:0] integ_nxt;
  logic signed [INT_W-1:0] integ;
  logic signed [INT_W-1:0] integ_sat;
  logic [1:0]              sat_f;

  assign rate_s  = rate;
  assign accel_s = accel_ang;
  assign acc_sum = acc + $signed({{CAL_LOG2{rate_s[W-1]}}, rate_s});
  assign rc      = $signed({rate_s[W-1], rate_s}) - $signed({offset[W-1], offset});
  assign angle_s = integ[INT_W-1:FRAC];

  // Fusion nudges toward the accel angle using the currently registered angle.
  always_comb begin
    fuse = '0;
    if (FUSE_EN) begin
      if (accel_s > angle_s)      fuse = NXT_W'(FUSE_STEP);
      else if (accel_s < angle_s) fuse = -NXT_W'(FUSE_STEP);
    end
  end

  assign integ_nxt = $signed({{2{integ[INT_W-1]}}, integ})
                   + $signed({{(NXT_W-W-1){rc[W]}}, rc})
                   + fuse;
  assign sat_f     = sat_flags(64'(integ_nxt), INT_W);
  assign integ_sat = sat_f[1] ? INT_MAX :
                     sat_f[0] ? INT_MIN : integ_nxt[INT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (clr)    acc <= '0;
    else if (cal_en) acc <= acc_sum;
  end

  // Top W bits of the full sum are the floor-shifted mean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        offset <= '0;
    else if (cal_last) offset <= acc_sum[ACC_W-1:CAL_LOG2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      integ <= '0;
    else if (clr)    integ <= '0;
    else if (run_en) integ <= integ_sat;
  end

  assign angle = angle_s;

endmodule

// File: rtl/inert_integrator_mc.sv
// Multi-channel gyro integrator: calibration FSM and sample counter shared
// across NUM_CH lockstep axis datapaths.
module inert_integrator_mc
  import inert_pkg::*;
#(
  parameter int                NUM_CH    = 3,
  parameter int                W         = 16,
  parameter int                FRAC      = 11,
  parameter int                CAL_LOG2  = 11,
  parameter logic [NUM_CH-1:0] FUSE_MASK = 3'b011,
  parameter int                FUSE_STEP = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strt_cal,
  input  logic                vld,
  input  logic [NUM_CH*W-1:0] rate,
  input  logic [NUM_CH*W-1:0] accel_ang,
  output logic [NUM_CH*W-1:0] angle,
  output logic                ang_vld,
  output logic                cal_done
);

  state_t              state;
  state_t              state_nxt;
  logic [CAL_LOG2-1:0] cnt;
  logic                cal_en;
  logic                cal_last;
  logic                run_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (strt_cal) begin
      state_nxt = CAL;
    end else begin
      case (state)
        CAL:     if (cal_last) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // strt_cal takes priority over a coincident sample.
  always_comb begin
    cal_en   = (state == CAL) && vld && !strt_cal;
    run_en   = (state == RUN) && vld && !strt_cal;
    cal_last = cal_en && (cnt == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (strt_cal) cnt <= '0;
    else if (cal_en)   cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ang_vld  <= 1'b0;
      cal_done <= 1'b0;
    end else begin
      ang_vld <= run_en;
      if (strt_cal)      cal_done <= 1'b0;
      else if (cal_last) cal_done <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_axis
    inert_axis #(
      .W        (W),
      .FRAC     (FRAC),
      .CAL_LOG2 (CAL_LOG2),
      .FUSE_EN  (FUSE_MASK[g]),
      .FUSE_STEP(FUSE_STEP)
    ) u_axis (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (strt_cal),
      .cal_en   (cal_en),
      .cal_last (cal_last),
      .run_en   (run_en),
      .rate     (rate[g*W +: W]),
      .accel_ang(accel_ang[g*W +: W]),
      .angle    (angle[g*W +: W])
    );
  end

endmodule

// File: tb/tb_inert_integrator_mc.sv
// Scoreboard bench for inert_integrator_mc with a short calibration window.
module tb_inert_integrator_mc;

  localparam int NUM_CH   = 3;
  localparam int W        = 16;
  localparam int CAL_LOG2 = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                strt_cal;
  logic                vld;
  logic [NUM_CH*W-1:0] rate;
  logic [NUM_CH*W-1:0] accel_ang;
  logic [NUM_CH*W-1:0] angle;
  logic                ang_vld;
  logic                cal_done;

  inert_integrator_mc #(
    .NUM_CH   (NUM_CH),
    .W        (W),
    .FRAC     (11),
    .CAL_LOG2 (CAL_LOG2),
    .FUSE_MASK(3'b011),
    .FUSE_STEP(1024)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_cal (strt_cal),
    .vld      (vld),
    .rate     (rate),
    .accel_ang(accel_ang),
    .angle    (angle),
    .ang_vld  (ang_vld),
    .cal_done (cal_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [47:0] ang;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void check(string name, logic [47:0] act, logic [47:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endfunction

  function automatic logic [47:0] pk(int a0, int a1, int a2);
    return {16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic drive(bit s, bit v, logic [47:0] r, logic [47:0] a);
    strt_cal  = s;
    vld       = v;
    rate      = r;
    accel_ang = a;
    @(posedge clk);
    #1;
    strt_cal = 1'b0;
    vld      = 1'b0;
  endtask

  task automatic run_vld(logic [47:0] r, logic [47:0] a, logic [47:0] expv, bit chk);
    exp_t x;
    x.chk = chk;
    x.ang = expv;
    sb.push_back(x);
    drive(1'b0, 1'b1, r, a);
  endtask

  // Monitor: every ang_vld pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ang_vld) begin
        if (sb.size() == 0) begin
          check("unexpected_ang_vld", 48'(ang_vld), 48'd0);
        end else begin
          e = sb.pop_front();
          if (e.chk) check("angle", angle, e.ang);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    strt_cal  = 1'b0;
    vld       = 1'b0;
    rate      = '0;
    accel_ang = '0;
    #12;
    check("reset_angle", angle, 48'd0);
    check("reset_ang_vld", 48'(ang_vld), 48'd0);
    check("reset_cal_done", 48'(cal_done), 48'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // IDLE ignores samples
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, pk(5, 5, 5), '0);

    // Calibration: offsets 100 / -50 / 0
    drive(1'b1, 1'b0, '0, '0);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, pk(100, -50, 0), '0);
      if (k == 7) check("cal_done_before_last", 48'(cal_done), 48'd0);
      if (k == 8) check("cal_done_on_last", 48'(cal_done), 48'd1);
    end

    // Integration: +1, +2, -1 angle LSB per sample; accel tracks angle on fused axes
    for (int k = 1; k <= 10; k++)
      run_vld(pk(2148, 4046, -2048), pk(k - 1, 2 * (k - 1), 1234),
              pk(k, 2 * k, -k), 1'b1);

    // Restart with a coincident sample
    drive(1'b1, 1'b1, pk(2148, 4046, -2048), '0);
    check("restart_angle", angle, 48'd0);
    check("restart_cal_done", 48'(cal_done), 48'd0);

    // Calibration with floor rounding: ch0 sum -7 -> offset -1, ch1 offset 10
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, pk((k < 8) ? -1 : 0, 10, 0), '0);
      if (k == 4) check("cal2_mid", 48'(cal_done), 48'd0);
    end
    check("cal2_done", 48'(cal_done), 48'd1);

    // Fusion: zero compensated rate, ch0 pulled toward 500 by 1024/2048 per sample
    for (int k = 1; k <= 1010; k++)
      run_vld(pk(-1, 10, 0), pk(500, 0, 500),
              pk(((k / 2) < 500) ? (k / 2) : 500, 0, 0), 1'b1);

    // Saturation: offsets 0, full-scale rates both directions
    drive(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, '0, '0);
    check("cal3_done", 48'(cal_done), 48'd1);
    for (int k = 1; k <= 2050; k++)
      run_vld(pk(32767, -32768, 0), pk(32767, -32768, 0),
              pk(32767, -32768, 0), k > 2000);

    // Asynchronous reset in RUN
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_run_angle", angle, 48'd0);
    check("rst_run_cal_done", 48'(cal_done), 48'd0);
    check("rst_run_ang_vld", 48'(ang_vld), 48'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset in CAL, then state must be IDLE again
    drive(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, pk(9, 9, 9), '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_cal_angle", angle, 48'd0);
    check("rst_cal_cal_done", 48'(cal_done), 48'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, pk(7, 7, 7), '0);
    check("idle_after_rst_cal_done", 48'(cal_done), 48'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 48'(sb.size()), 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
